// File: rtl/analog_switch_sequencer.sv
// Break-before-make sequencer for the analog pad pass-gates: single channel or ascending masked scan.
// All outputs registered; sw_en asserts DEAD+1 cycles after start is accepted; abort/rst open every switch on the next edge.
module analog_switch_sequencer #(
  parameter int NCH  = 6,
  parameter int DEAD = 4,
  parameter int DW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           scan,
  input  logic [2:0]     ch_sel,
  input  logic [NCH-1:0] ch_mask,
  input  logic [DW-1:0]  dwell,
  output logic [NCH-1:0] sw_en,
  output logic [2:0]     cur_ch,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int DCW = $clog2(DEAD + 1);
  localparam int CW  = (DW > DCW) ? DW : DCW;
  localparam logic [3:0] NCH_W = 4'(NCH);

  typedef enum logic [1:0] {IDLE, BREAK, MAKE, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           scan_q, scan_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [2:0]     cur_ch_q, cur_ch_d;
  logic [NCH-1:0] sw_en_q, sw_en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [2:0]     first_ch;
  logic [2:0]     next_ch;
  logic           has_next;
  logic           sel_bad;

  // Descending loop so the last hit is the lowest qualifying bit.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
      if (mask_q[i] && (i > int'(cur_ch_q))) begin
        next_ch  = 3'(i);
        has_next = 1'b1;
      end
    end
  end

  assign sel_bad = ({1'b0, ch_sel} >= NCH_W);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scan_d   = scan_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    cur_ch_d = cur_ch_q;
    sw_en_d  = sw_en_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (scan ? (ch_mask == '0) : sel_bad) begin
            err_d = 1'b1;
          end else begin
            state_d  = BREAK;
            scan_d   = scan;
            mask_d   = ch_mask;
            dwell_d  = (dwell == '0) ? DW'(1) : dwell;
            cur_ch_d = scan ? first_ch : ch_sel;
            cnt_d    = CW'(DEAD - 1);
            sw_en_d  = '0;
          end
        end
      end
      BREAK: begin
        if (cnt_q == '0) begin
          state_d = MAKE;
          sw_en_d = NCH'(1) << cur_ch_q;
          cnt_d   = CW'(dwell_q) - CW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MAKE: begin
        if (cnt_q == '0) begin
          sw_en_d = '0;
          if (scan_q && has_next) begin
            state_d  = BREAK;
            cur_ch_d = next_ch;
            cnt_d    = CW'(DEAD - 1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sw_en_d = '0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      sw_en_d = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scan_q   <= 1'b0;
      mask_q   <= '0;
      dwell_q  <= '0;
      cur_ch_q <= '0;
      sw_en_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scan_q   <= scan_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      cur_ch_q <= cur_ch_d;
      sw_en_q  <= sw_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sw_en  = sw_en_q;
  assign cur_ch = cur_ch_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_analog_switch_sequencer.sv
// Directed bench for analog_switch_sequencer with a per-cycle break-before-make monitor.
module tb_analog_switch_sequencer;
  localparam int NCH  = 6;
  localparam int DEAD = 4;
  localparam int DW   = 8;

  logic           clk = 1'b0;
  logic           rst, start, abort, scan;
  logic [2:0]     ch_sel;
  logic [NCH-1:0] ch_mask;
  logic [DW-1:0]  dwell;
  logic [NCH-1:0] sw_en;
  logic [2:0]     cur_ch;
  logic           busy, done, err;

  analog_switch_sequencer #(.NCH(NCH), .DEAD(DEAD), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .scan(scan),
    .ch_sel(ch_sel), .ch_mask(ch_mask), .dwell(dwell),
    .sw_en(sw_en), .cur_ch(cur_ch), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [NCH-1:0] sw_t [0:39];
  logic [2:0]     cc_t [0:39];
  logic           bz_t [0:39];
  logic           dn_t [0:39];
  logic           er_t [0:39];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index i holds the outputs of cycle k+i, where k is the edge that samples start.
  task automatic capture(input int n, input bit hold, input bit scramble);
    for (int i = 1; i <= n; i++) begin
      tick();
      sw_t[i] = sw_en;
      cc_t[i] = cur_ch;
      bz_t[i] = busy;
      dn_t[i] = done;
      er_t[i] = err;
      if (!hold) start = 1'b0;
      if (scramble && i == 1) begin
        ch_sel  = 3'd1;
        dwell   = 8'd9;
        scan    = 1'b1;
        ch_mask = 6'b111111;
      end
    end
  endtask

  function automatic int n_done(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (dn_t[i]) c++;
    return c;
  endfunction

  function automatic int n_busy(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (bz_t[i]) c++;
    return c;
  endfunction

  function automatic int n_on(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (sw_t[i] != '0) c++;
    return c;
  endfunction

  function automatic int first_on(input int n);
    for (int i = 1; i <= n; i++) if (sw_t[i] != '0) return i;
    return 0;
  endfunction

  int             gap = 0;
  logic [NCH-1:0] prev_sw = '0;
  bit             seen_on = 1'b0;

  always @(negedge clk) begin
    if (sw_en != '0) begin
      check("onehot", 32'($onehot(sw_en)), 32'd1);
      if (prev_sw != '0) check("no_hop", 32'(sw_en), 32'(prev_sw));
      else if (seen_on) check("bbm_gap", 32'(gap >= DEAD), 32'd1);
      seen_on = 1'b1;
      gap     = 0;
    end else begin
      gap++;
    end
    prev_sw = sw_en;
  end

  task automatic check_zero(input string tag);
    check({tag, "_sw"},   32'(sw_en),  32'd0);
    check({tag, "_busy"}, 32'(busy),   32'd0);
    check({tag, "_done"}, 32'(done),   32'd0);
    check({tag, "_err"},  32'(err),    32'd0);
    check({tag, "_ch"},   32'(cur_ch), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; scan = 1'b0;
    ch_sel = '0; ch_mask = '0; dwell = '0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Single channel 2, dwell 5
    scan = 1'b0; ch_sel = 3'd2; dwell = 8'd5; start = 1'b1;
    capture(14, 1'b0, 1'b0);
    check("single_first_on", 32'(first_on(14)), 32'd5);
    check("single_on_cnt",   32'(n_on(14)),     32'd5);
    check("single_sw",       32'(sw_t[7]),      32'b000100);
    check("single_curch",    32'(cc_t[5]),      32'd2);
    check("single_done_cnt", 32'(n_done(14)),   32'd1);
    check("single_done_at",  32'(dn_t[10]),     32'd1);
    check("single_busy_cnt", 32'(n_busy(14)),   32'd10);
    check("single_busy_end", 32'(bz_t[11]),     32'd0);
    tick();

    // Scan 101001, dwell 3
    scan = 1'b1; ch_mask = 6'b101001; dwell = 8'd3; start = 1'b1;
    capture(25, 1'b0, 1'b0);
    check("scan_brk0",   32'(sw_t[4]),  32'd0);
    check("scan_ch0_a",  32'(sw_t[5]),  32'b000001);
    check("scan_ch0_b",  32'(sw_t[7]),  32'b000001);
    check("scan_brk1",   32'(sw_t[8]),  32'd0);
    check("scan_brk1_e", 32'(sw_t[11]), 32'd0);
    check("scan_ch3_a",  32'(sw_t[12]), 32'b001000);
    check("scan_ch3_b",  32'(sw_t[14]), 32'b001000);
    check("scan_ch5_a",  32'(sw_t[19]), 32'b100000);
    check("scan_ch5_b",  32'(sw_t[21]), 32'b100000);
    check("scan_off",    32'(sw_t[22]), 32'd0);
    check("scan_on_cnt", 32'(n_on(25)), 32'd9);
    check("scan_cc0",    32'(cc_t[5]),  32'd0);
    check("scan_cc3",    32'(cc_t[12]), 32'd3);
    check("scan_cc5",    32'(cc_t[19]), 32'd5);
    check("scan_done_n", 32'(n_done(25)), 32'd1);
    check("scan_done_at", 32'(dn_t[22]), 32'd1);
    check("scan_busy_n", 32'(n_busy(25)), 32'd22);

    // Rejected starts
    scan = 1'b0; ch_sel = 3'd6; start = 1'b1;
    capture(3, 1'b0, 1'b0);
    check("errsel_pulse", 32'(er_t[1]),    32'd1);
    check("errsel_once",  32'(er_t[2]),    32'd0);
    check("errsel_busy",  32'(n_busy(3)),  32'd0);
    check("errsel_sw",    32'(n_on(3)),    32'd0);
    scan = 1'b1; ch_mask = '0; start = 1'b1;
    capture(3, 1'b0, 1'b0);
    check("errmask_pulse", 32'(er_t[1]),   32'd1);
    check("errmask_once",  32'(er_t[2]),   32'd0);
    check("errmask_busy",  32'(n_busy(3)), 32'd0);
    check("errmask_sw",    32'(n_on(3)),   32'd0);

    // Abort in second MAKE cycle of a scan
    scan = 1'b1; ch_mask = 6'b101001; dwell = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_pre_sw", 32'(sw_en), 32'b000001);
    abort = 1'b1;
    tick();
    check("abort_sw",   32'(sw_en), 32'd0);
    check("abort_busy", 32'(busy),  32'd0);
    check("abort_done", 32'(done),  32'd0);
    abort = 1'b0;
    capture(10, 1'b0, 1'b0);
    check("abort_no_done", 32'(n_done(10)), 32'd0);
    check("abort_idle",    32'(n_busy(10)), 32'd0);

    // Fresh single run after abort
    scan = 1'b0; ch_sel = 3'd1; dwell = 8'd2; start = 1'b1;
    capture(9, 1'b0, 1'b0);
    check("fresh_sw_a", 32'(sw_t[5]), 32'b000010);
    check("fresh_sw_b", 32'(sw_t[6]), 32'b000010);
    check("fresh_off",  32'(sw_t[7]), 32'd0);
    check("fresh_done", 32'(dn_t[7]), 32'd1);
    check("fresh_idle", 32'(bz_t[8]), 32'd0);

    // Reset in BREAK
    ch_sel = 3'd4; dwell = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rstbrk_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_zero("rstbrk");
    rst = 1'b0;
    tick();

    // Reset in MAKE
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("rstmk_pre_sw", 32'(sw_en), 32'b010000);
    rst = 1'b1;
    tick();
    check_zero("rstmk");
    rst = 1'b0;
    tick();

    // dwell=0 with inputs changed during the run
    scan = 1'b0; ch_sel = 3'd3; dwell = 8'd0; ch_mask = '0; start = 1'b1;
    capture(12, 1'b0, 1'b1);
    check("d0_sw",     32'(sw_t[5]),    32'b001000);
    check("d0_cc",     32'(cc_t[5]),    32'd3);
    check("d0_off",    32'(sw_t[6]),    32'd0);
    check("d0_on_cnt", 32'(n_on(12)),   32'd1);
    check("d0_done",   32'(dn_t[6]),    32'd1);
    check("d0_busy_n", 32'(n_busy(12)), 32'd6);

    // start held high across DONE: one IDLE cycle, then a new run
    scan = 1'b0; ch_sel = 3'd0; dwell = 8'd1; start = 1'b1;
    capture(9, 1'b1, 1'b0);
    check("hold_done",  32'(dn_t[6]), 32'd1);
    check("hold_busy6", 32'(bz_t[6]), 32'd1);
    check("hold_gap",   32'(bz_t[7]), 32'd0);
    check("hold_rerun", 32'(bz_t[8]), 32'd1);
    start = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/analog_switch_sequencer.md
# analog_switch_sequencer

Sequences the analog pass-gate enables that connect on-die analog test structures to the ua[5:0] pads of the tt_um_copia29 tile. A single digital controller, driven from the dedicated inputs, guarantees break-before-make switching, a programmable dwell per channel, and single-channel or masked-scan operation. Status is returned on the bidirectional IO bank.

## Interface
Parameters:
- NCH, 6, number of analog channels (one switch enable per usable ua pad; 1..8)
- DEAD, 4, break-before-make dead time in clk cycles (>=1)
- DW, 8, dwell counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  level-sampled request; acted on only in IDLE
- abort  in  1  forces all switches open and returns to IDLE
- scan  in  1  0 = single channel ch_sel; 1 = scan channels set in ch_mask, ascending
- ch_sel  in  3  channel index for single mode
- ch_mask  in  NCH  scan enable mask
- dwell  in  DW  dwell length in cycles; 0 is treated as 1
- sw_en  out  NCH  one-hot (or all-zero) analog switch enables
- cur_ch  out  3  channel currently connected (valid while sw_en != 0)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, BREAK, MAKE, DONE.
- Reset values: state IDLE; sw_en 0; cur_ch 0; busy 0; done 0; err 0; counters 0.
- start, scan, ch_sel, ch_mask and dwell are latched on the cycle that start is accepted. Later input changes have no effect until the next run.
- IDLE with start=1:
  - Single mode, ch_sel >= NCH: err pulses and the block stays in IDLE.
  - Scan mode, ch_mask == 0: err pulses and the block stays in IDLE.
  - Otherwise: the first channel is the lowest set mask bit (scan) or ch_sel (single). Go to BREAK.
- BREAK: sw_en = 0 for exactly DEAD cycles, then go to MAKE.
- MAKE: sw_en = 1<<cur_ch for max(dwell,1) cycles. On expiry:
  - Scan mode with a higher masked channel remaining: load the next channel and go to BREAK.
  - Otherwise: go to DONE.
- DONE: sw_en = 0, done = 1 for one cycle, then IDLE. busy is still high in DONE.
- abort in any non-IDLE state: next cycle sw_en = 0 and state IDLE. No done pulse is issued.
- abort and start together in IDLE: abort wins and start is ignored.
- Invariants:
  - popcount(sw_en) <= 1 in every cycle.
  - Any change of the connected channel has at least DEAD cycles of sw_en = 0 in between.
- rst mid-run: on the next edge all outputs return to their reset values. No glitch onto a second channel.
- Scan does not wrap. A run ends after the highest set mask bit.

## Timing
- All outputs are registered. No combinational path from any input to sw_en.
- start accepted at edge k: busy = 1 and sw_en = 0 from k+1.
- sw_en asserts at k+1+DEAD and stays high for dwell cycles.
- Single run:
  - done is high in cycle k+1+DEAD+dwell.
  - busy falls one cycle later.
  - Total occupancy is DEAD+dwell+1 cycles.
- Scan of M channels: each channel costs DEAD+dwell cycles, plus 1 cycle for DONE.
- err pulses in cycle k+1. busy stays 0.
- start held high across DONE: a new run is accepted on the first IDLE cycle. There is a minimum gap of 1 IDLE cycle between runs.

## Test plan
- Reset, then single run with ch_sel=2, dwell=5, DEAD=4 -> sw_en=000100 for exactly 5 cycles starting 5 cycles after the start edge; done pulses once; busy spans 10 cycles.
- Scan with ch_mask=101001, dwell=3 -> sw_en goes 000001, 001000, 100000, each held 3 cycles and separated by 4 zero cycles; cur_ch is 0, 3, 5; a single done pulse at the end.
- Errors:
  - ch_sel=6 with NCH=6 -> err pulse; busy and sw_en stay 0.
  - Scan with ch_mask=0 -> err pulse; busy and sw_en stay 0.
- abort asserted in the 2nd MAKE cycle of a scan -> sw_en=0 and busy=0 on the next cycle; no done pulse. A fresh start afterwards runs normally.
- rst asserted mid-BREAK and mid-MAKE -> all outputs are zero the next cycle. Throughout every test, an assertion checks popcount(sw_en) <= 1 and a gap of at least DEAD cycles between channels.
- dwell=0, and inputs changed during a run -> effective dwell is 1; the latched configuration is unaffected by the changes.
